// File: rtl/cz80_clock_scheduler_if.sv
// Bus between the cz80 core side and the clock scheduler: speed request,
// CPU cycle indicators, external wait, and the generated enable/wait strobes.
interface cz80_clock_scheduler_if;
  logic [1:0] speed_sel;
  logic       m1_n;
  logic       iorq_n;
  logic       ext_wait_n;
  logic       enable;
  logic       wait_n;
  logic [1:0] speed_cur;
  logic       busy;

  modport master (
    output speed_sel, m1_n, iorq_n, ext_wait_n,
    input  enable, wait_n, speed_cur, busy
  );

  modport slave (
    input  speed_sel, m1_n, iorq_n, ext_wait_n,
    output enable, wait_n, speed_cur, busy
  );
endinterface

// File: rtl/cz80_clock_scheduler.sv
// Clock-enable divider (/24, /12, /6, /4) and M1/IO wait-state inserter for cz80.
// Speed changes take effect only at a period boundary, so no short or long pulse is produced.
module cz80_clock_scheduler #(
  parameter int unsigned M1_WAITS = 1,
  parameter int unsigned IO_WAITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  cz80_clock_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_M1WAIT = 2'd1,
    ST_IOWAIT = 2'd2
  } state_e;

  localparam logic [2:0] M1_LOAD = M1_WAITS[2:0];
  localparam logic [2:0] IO_LOAD = IO_WAITS[2:0];

  // Reload value is the divide ratio minus one so the period is exactly div().
  function automatic logic [4:0] div_reload(input logic [1:0] code);
    logic [4:0] val;
    case (code)
      2'd0:    val = 5'd23;
      2'd1:    val = 5'd11;
      2'd2:    val = 5'd5;
      2'd3:    val = 5'd3;
      default: val = 5'd23;
    endcase
    return val;
  endfunction

  logic [4:0] cnt_q, cnt_d;
  logic [1:0] ratio_q, ratio_d;
  logic       enable_q, enable_d;
  logic       m1_prev_q, m1_prev_d;
  logic       iorq_prev_q, iorq_prev_d;
  state_e     state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;

  logic       m1_start_s;
  logic       io_start_s;
  logic       busy_s;
  logic       wait_n_s;

  always_comb begin
    cnt_d    = cnt_q;
    ratio_d  = ratio_q;
    enable_d = 1'b0;
    if (cnt_q == 5'd0) begin
      ratio_d  = bus.speed_sel;
      cnt_d    = div_reload(bus.speed_sel);
      enable_d = 1'b1;
    end else begin
      cnt_d    = cnt_q - 5'd1;
      enable_d = 1'b0;
    end
  end

  // Start events compare the CPU strobes against their value at the previous enable.
  always_comb begin
    m1_prev_d   = m1_prev_q;
    iorq_prev_d = iorq_prev_q;
    if (enable_q) begin
      m1_prev_d   = bus.m1_n;
      iorq_prev_d = bus.iorq_n;
    end else begin
      m1_prev_d   = m1_prev_q;
      iorq_prev_d = iorq_prev_q;
    end
    m1_start_s = enable_q & m1_prev_q & ~bus.m1_n;
    io_start_s = enable_q & iorq_prev_q & ~bus.iorq_n & bus.m1_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= 5'd0;
      ratio_q     <= 2'd0;
      enable_q    <= 1'b0;
      m1_prev_q   <= 1'b1;
      iorq_prev_q <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      enable_q    <= enable_d;
      m1_prev_q   <= m1_prev_d;
      iorq_prev_q <= iorq_prev_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // A fresh start event always restarts the count, M1 taking precedence over IO.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (m1_start_s && (M1_LOAD != 3'd0)) begin
      state_d = ST_M1WAIT;
      wcnt_d  = M1_LOAD;
    end else if (io_start_s && (IO_LOAD != 3'd0)) begin
      state_d = ST_IOWAIT;
      wcnt_d  = IO_LOAD;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
          wcnt_d  = 3'd0;
        end
        ST_M1WAIT, ST_IOWAIT: begin
          if (enable_q) begin
            if (wcnt_q <= 3'd1) begin
              state_d = ST_IDLE;
              wcnt_d  = 3'd0;
            end else begin
              state_d = state_q;
              wcnt_d  = wcnt_q - 3'd1;
            end
          end else begin
            state_d = state_q;
            wcnt_d  = wcnt_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          wcnt_d  = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    busy_s = 1'b0;
    if (state_q != ST_IDLE) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
    wait_n_s = ~busy_s & bus.ext_wait_n;
  end

  assign bus.enable    = enable_q;
  assign bus.speed_cur = ratio_q;
  assign bus.busy      = busy_s;
  assign bus.wait_n    = wait_n_s;

endmodule

// File: doc/cz80_clock_scheduler.md
# cz80_clock_scheduler

Clock-enable and wait-state controller for the cz80 core. Divides the 85.909 MHz system clock into a single-cycle `enable` strobe at one of four MSX CPU speeds (3.58/7.16/14.32/21.48 MHz). Switches speed glitch-free at period boundaries. Inserts programmable M1 and I/O wait states on `wait_n`. Sits between the system clock tree and `cz80_inst`, and drives that core's `enable` and `wait_n` inputs.

## Interface
Parameters:
- `M1_WAITS`, default 1: wait states inserted per opcode fetch (0–7; 0 disables).
- `IO_WAITS`, default 1: wait states inserted per I/O cycle (0–7; 0 disables).

Ports:
- `clk` in 1: system clock, 85.909 MHz.
- `reset` in 1: asynchronous, active-high reset.
- `speed_sel` in 2: requested speed. 0 = ÷24, 1 = ÷12, 2 = ÷6, 3 = ÷4.
- `m1_n` in 1: CPU M1 (active low), driven by the core.
- `iorq_n` in 1: CPU IORQ (active low), driven by the core.
- `ext_wait_n` in 1: external wait request (active low), ANDed into `wait_n`.
- `enable` out 1: CPU clock-enable, one `clk` wide.
- `wait_n` out 1: CPU WAIT (active low).
- `speed_cur` out 2: speed code currently in effect.
- `busy` out 1: high while an inserted wait sequence is active.

## Operation
- Divider:
  - 5-bit down-counter `cnt` and registered `ratio` code.
  - On a `clk` edge with `cnt==0`: load `ratio <= speed_sel`, load `cnt <= div(speed_sel)-1`, set `enable <= 1`.
  - Otherwise: `cnt <= cnt-1`, `enable <= 0`.
  - `div()` = 24/12/6/4. The `enable` period equals `div()` exactly; there is no off-by-one.
- Speed change:
  - `speed_sel` is sampled only on the reload edge.
  - A change mid-period never shortens or stretches the current period.
  - The new period starts at the next `enable`.
  - `speed_cur` = `ratio`.
- Bus-cycle edge detect:
  - `m1_d` and `iorq_d` register `m1_n` and `iorq_n`, updated only on clocks where `enable==1`.
  - M1 start = `enable & m1_d & ~m1_n`.
  - IO start = `enable & iorq_d & ~iorq_n & m1_n`. Interrupt acknowledge counts as M1 only.
- FSM states: ST_IDLE, ST_M1WAIT, ST_IOWAIT. A 3-bit `wcnt` accompanies the FSM.
  - ST_IDLE: on M1 start with `M1_WAITS≠0`, load `wcnt=M1_WAITS` and go to ST_M1WAIT. On IO start with `IO_WAITS≠0`, load `wcnt=IO_WAITS` and go to ST_IOWAIT.
  - ST_M1WAIT / ST_IOWAIT: on each `enable`, `wcnt` decrements. When `wcnt` reaches 0, go to ST_IDLE.
  - A new start event while in a wait state reloads `wcnt` with the new event's value and moves to that event's state. M1 has priority if both start events fire together.
- Outputs:
  - `busy = (state≠ST_IDLE)`.
  - `wait_n = ~busy & ext_wait_n`. This is combinational from registers plus `ext_wait_n`.
- `ext_wait_n` does not pause `wcnt`. Inserted and external waits overlap; they do not add.

## Timing
- Reset values:
  - `cnt=0`, `ratio=0`, `enable=0`, `speed_cur=0`.
  - `m1_d=1`, `iorq_d=1`.
  - FSM = ST_IDLE, `wcnt=0`, `busy=0`.
  - `wait_n` = `ext_wait_n`.
- After reset deasserts:
  - First `enable` on the first `clk` rising edge.
  - Subsequent `enable`s every `div(speed_cur)` clocks.
- Wait latency: `wait_n` falls one `clk` after the `enable` clock that detects the M1/IO start. It stays low for exactly `wcnt` enable periods.
- Speed switch to 3 at any phase: the next `enable` interval keeps the old ratio; all following intervals are 4 clocks.
- Reset asserted mid-wait or mid-period:
  - All outputs return to reset values asynchronously.
  - `wait_n` releases immediately, unless `ext_wait_n` is low.
- `speed_sel` and the CPU inputs must be synchronous to `clk`. No internal synchronizers.

## Test plan
- Reset, `speed_sel=0`, run 200 clocks: `enable` pulses at clocks 1, 25, 49, …; every gap is exactly 24; `speed_cur=0`.
- Switch `speed_sel` 0→1→2→3, each change at a random mid-period clock: gaps go 24…24, 12…, 6…, 4…; no gap is shorter than the new ratio and no extra pulse appears at any switch.
- `m1_n` falls before an `enable`, with `M1_WAITS=1`: `wait_n` low for exactly 24 clocks at speed 0 and 4 clocks at speed 3; `busy` tracks it.
- `iorq_n` falls with `m1_n` high, `IO_WAITS=3`: `wait_n` low for 3 enable periods. Same with `m1_n` low (INTA): the M1_WAITS count is used instead.
- `ext_wait_n` held low for 10 enables, overlapping an M1 wait: `wait_n` is the AND of both; the inserted wait still ends after `M1_WAITS` enables.
- Assert `reset` during ST_IOWAIT at speed 2: `wait_n=1`, `enable=0`, `speed_cur=0`, `busy=0` immediately. After release, the first `enable` comes on the next edge.
